// File: rtl/dmem_responder.sv
// Data-memory responder for the M stage: a circular write buffer with load forwarding
// that drains stores into a single-port word SRAM with a multi-cycle write occupancy.
module dmem_responder #(
  parameter int DEPTH        = 4,
  parameter int MEMWORDS     = 64,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memreadM,
  input  logic                     memwriteM,
  input  logic [31:0]              addrM,
  input  logic [31:0]              writedataM,
  output logic [31:0]              readdataM,
  output logic                     stallM,
  output logic [$clog2(DEPTH):0]   bufcount,
  output logic                     idle
);

  localparam int AW  = $clog2(MEMWORDS);
  localparam int PW  = $clog2(DEPTH);
  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [PW:0]    FULL_COUNT  = (PW + 1)'(DEPTH);
  localparam logic [DCW-1:0] DRAIN_START = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    LOAD_WAIT
  } stateT;

  stateT          state;
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [DCW-1:0] drainCnt;
  logic [31:0]    sramQ;

  logic [AW-1:0]  bufAddr [DEPTH];
  logic [31:0]    bufData [DEPTH];
  logic [31:0]    sram    [MEMWORDS];

  logic [AW-1:0]  wordIdx;
  logic           isStore;
  logic           isLoad;
  logic           bufFull;
  logic           hit;
  logic [31:0]    hitData;
  logic           loadMiss;
  logic           pushEn;
  logic           popEn;
  logic           unusedAddrBits;

  assign wordIdx        = addrM[AW+1:2];
  assign unusedAddrBits = ^{addrM[31:AW+2], addrM[1:0]};

  // A store wins over a simultaneous read; the read half is simply dropped.
  assign isStore  = memwriteM;
  assign isLoad   = memreadM & ~memwriteM;
  assign bufFull  = (bufcount == FULL_COUNT);
  assign loadMiss = isLoad & ~hit;
  assign pushEn   = isStore & ~bufFull;
  assign popEn    = ~reset && (state == DRAIN) && (drainCnt == '0);
  assign idle     = (state == IDLE) && (bufcount == '0);

  // Walk the live entries oldest to youngest so the last match seen is the youngest one.
  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PW + 1)'(i) < bufcount) && (bufAddr[head + PW'(i)] == wordIdx)) begin
        hit     = 1'b1;
        hitData = bufData[head + PW'(i)];
      end
    end
  end

  always_comb begin
    stallM    = 1'b0;
    readdataM = '0;
    if (!reset) begin
      if (isStore) begin
        stallM = bufFull;
      end else if (isLoad) begin
        if (hit) begin
          readdataM = hitData;
        end else if (state == LOAD_WAIT) begin
          readdataM = sramQ;
        end else begin
          stallM = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      head     <= '0;
      tail     <= '0;
      bufcount <= '0;
      drainCnt <= '0;
    end else begin
      if (pushEn) begin
        tail <= tail + PW'(1);
      end
      if (popEn) begin
        head <= head + PW'(1);
      end
      case ({pushEn, popEn})
        2'b10:   bufcount <= bufcount + (PW + 1)'(1);
        2'b01:   bufcount <= bufcount - (PW + 1)'(1);
        default: bufcount <= bufcount;
      endcase

      // A waiting load miss always gets the SRAM port before a new drain begins.
      case (state)
        IDLE: begin
          if (loadMiss) begin
            state <= LOAD_WAIT;
          end else if (bufcount != '0) begin
            state    <= DRAIN;
            drainCnt <= DRAIN_START;
          end
        end
        DRAIN: begin
          if (drainCnt != '0) begin
            drainCnt <= drainCnt - DCW'(1);
          end else begin
            state <= IDLE;
          end
        end
        LOAD_WAIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (pushEn) begin
      bufAddr[tail] <= wordIdx;
      bufData[tail] <= writedataM;
    end
  end

  // The SRAM is not reset; reads and writes never share an edge since reads only issue from IDLE.
  always_ff @(posedge clk) begin
    if (popEn) begin
      sram[bufAddr[head]] <= bufData[head];
    end
    if (!reset && (state == IDLE) && loadMiss) begin
      sramQ <= sram[wordIdx];
    end
  end

endmodule
